sd_sector_buffer: RTL and testbench

- Sits directly downstream of the SD SPI single-block reader. It sequences consecutive CMD17 sector reads through the reader's read_ready/read_busy handshake.
- Captures each 256-word (512-byte) sector from the reader's read_request/read_data strobes into a ping-pong buffer of two 256x16 banks.
- Streams completed sectors to the application over a valid/ready word interface, so SD fetching overlaps with consumption.

---
 rtl/sd_sector_buffer_if.sv | 24 ++
 rtl/sd_sector_buffer.sv | 197 +++++++++++++++++++
 tb/tb_sd_sector_buffer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_buffer_if.sv
// Reader-side and stream-side signals of the SD sector ping-pong buffer.
// master is the buffer itself; slave is the SD reader plus the consumer.
interface sd_sector_buffer_if;
    logic        read_ready;
    logic        read_busy;
    logic        read_request;
    logic [15:0] read_data;
    logic [31:0] read_address;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [15:0] out_sector;

    modport master (
        output read_ready, read_address, out_valid, out_data, out_last, out_sector,
        input  read_busy, read_request, read_data, out_ready
    );

    modport slave (
        input  read_ready, read_address, out_valid, out_data, out_last, out_sector,
        output read_busy, read_request, read_data, out_ready
    );
endinterface

// File: rtl/sd_sector_buffer.sv
// Sequences CMD17 sector reads into a two-bank ping-pong buffer and streams
// each completed sector out over valid/ready while the next one is fetched.
module sd_sector_buffer #(
    parameter logic [31:0] START_SECTOR = 32'd0,
    parameter int unsigned SECTOR_COUNT = 16,
    parameter logic [31:0] ADDR_STEP    = 32'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    output logic              done,
    output logic              err,
    sd_sector_buffer_if.master bus
);
    localparam logic [15:0] SEC_TOTAL   = 16'(SECTOR_COUNT);
    localparam logic [15:0] LAST_SECTOR = 16'(SECTOR_COUNT - 1);

    typedef enum logic [2:0] {W_WAIT_INIT, W_REQ, W_FILL, W_COMMIT, W_STALL, W_DONE} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

    logic [15:0] mem [0:511];

    wstate_t     w_state, w_state_nxt;
    logic [8:0]  wcnt, wcnt_nxt;
    logic        wbank, wbank_nxt;
    logic [15:0] sec_cnt, sec_cnt_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic        err_nxt;
    logic        wr_en;

    rstate_t     r_state, r_state_nxt;
    logic        rbank, rbank_nxt;
    logic [7:0]  ridx, ridx_nxt;
    logic [15:0] out_sector_q, out_sector_nxt;
    logic        done_nxt;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [15:0] rd_data_p1;

    logic [1:0]  full, full_nxt;
    logic        hs, release_bank, other_free;

    assign hs           = (r_state == R_STREAM) && bus.out_ready;
    assign release_bank = hs && (ridx == 8'd255);
    // A bank released by the reader this very cycle already counts as empty.
    assign other_free   = !full[~wbank] || (release_bank && (rbank != wbank));

    always_comb begin
        w_state_nxt = w_state;
        wcnt_nxt    = wcnt;
        wbank_nxt   = wbank;
        sec_cnt_nxt = sec_cnt;
        addr_nxt    = addr_q;
        err_nxt     = err;
        wr_en       = 1'b0;
        case (w_state)
            W_WAIT_INIT: if (init_done && !bus.read_busy) w_state_nxt = W_REQ;
            W_REQ: begin
                if (bus.read_busy) begin
                    w_state_nxt = W_FILL;
                    wcnt_nxt    = '0;
                end
            end
            W_FILL: begin
                if (bus.read_request) begin
                    if (wcnt[8]) begin
                        err_nxt = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wcnt_nxt = wcnt + 9'd1;
                    end
                end
                // Busy falling short of a full sector means the block is re-read.
                if (!bus.read_busy) begin
                    if (wcnt_nxt[8]) begin
                        w_state_nxt = W_COMMIT;
                    end else begin
                        err_nxt     = 1'b1;
                        wcnt_nxt    = '0;
                        w_state_nxt = W_REQ;
                    end
                end
            end
            W_COMMIT: begin
                sec_cnt_nxt = sec_cnt + 16'd1;
                addr_nxt    = addr_q + ADDR_STEP;
                wcnt_nxt    = '0;
                if (sec_cnt_nxt == SEC_TOTAL) begin
                    w_state_nxt = W_DONE;
                end else if (other_free && !bus.read_busy) begin
                    wbank_nxt   = ~wbank;
                    w_state_nxt = W_REQ;
                end else begin
                    w_state_nxt = W_STALL;
                end
            end
            W_STALL: begin
                if (other_free && !bus.read_busy) begin
                    wbank_nxt   = ~wbank;
                    w_state_nxt = W_REQ;
                end
            end
            W_DONE:  w_state_nxt = W_DONE;
            default: w_state_nxt = W_WAIT_INIT;
        endcase
    end

    always_comb begin
        r_state_nxt    = r_state;
        rbank_nxt      = rbank;
        ridx_nxt       = ridx;
        out_sector_nxt = out_sector_q;
        done_nxt       = done;
        rd_en          = 1'b0;
        rd_addr        = {rbank, ridx};
        case (r_state)
            R_IDLE: if (full[rbank]) r_state_nxt = R_FETCH;
            R_FETCH: begin
                rd_en       = 1'b1;
                rd_addr     = {rbank, 8'd0};
                ridx_nxt    = '0;
                r_state_nxt = R_STREAM;
            end
            R_STREAM: begin
                if (hs) begin
                    if (ridx == 8'd255) begin
                        rbank_nxt      = ~rbank;
                        ridx_nxt       = '0;
                        out_sector_nxt = out_sector_q + 16'd1;
                        if (out_sector_q == LAST_SECTOR) done_nxt = 1'b1;
                        if (full[~rbank]) begin
                            rd_en   = 1'b1;
                            rd_addr = {~rbank, 8'd0};
                        end else begin
                            r_state_nxt = R_IDLE;
                        end
                    end else begin
                        ridx_nxt = ridx + 8'd1;
                        rd_en    = 1'b1;
                        rd_addr  = {rbank, ridx_nxt};
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        full_nxt = full;
        if (w_state == W_COMMIT) full_nxt[wbank] = 1'b1;
        if (release_bank)        full_nxt[rbank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wbank, wcnt[7:0]}] <= bus.read_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state      <= W_WAIT_INIT;
            wcnt         <= '0;
            wbank        <= 1'b0;
            sec_cnt      <= '0;
            addr_q       <= START_SECTOR;
            err          <= 1'b0;
            r_state      <= R_IDLE;
            rbank        <= 1'b0;
            ridx         <= '0;
            out_sector_q <= '0;
            done         <= 1'b0;
            full         <= '0;
            rd_data_p1   <= '0;
        end else begin
            w_state      <= w_state_nxt;
            wcnt         <= wcnt_nxt;
            wbank        <= wbank_nxt;
            sec_cnt      <= sec_cnt_nxt;
            addr_q       <= addr_nxt;
            err          <= err_nxt;
            r_state      <= r_state_nxt;
            rbank        <= rbank_nxt;
            ridx         <= ridx_nxt;
            out_sector_q <= out_sector_nxt;
            done         <= done_nxt;
            full         <= full_nxt;
            // RAM read stage: data lands one cycle after the address is chosen.
            if (rd_en) rd_data_p1 <= mem[rd_addr];
        end
    end

    assign bus.read_ready   = (w_state == W_REQ);
    assign bus.read_address = addr_q;
    assign bus.out_valid    = (r_state == R_STREAM);
    assign bus.out_data     = rd_data_p1;
    assign bus.out_last     = (r_state == R_STREAM) && (ridx == 8'd255);
    assign bus.out_sector   = out_sector_q;
endmodule

// File: tb/tb_sd_sector_buffer.sv
// Bench for sd_sector_buffer: a behavioural SD reader and a consumer with
// several readiness patterns, checked against the expected sector stream.
module tb_sd_sector_buffer;
    localparam logic [31:0] START = 32'd0;
    localparam int          NSEC  = 4;
    localparam logic [31:0] STEP  = 32'd512;

    logic clk;
    logic rst_n;
    logic init_done;
    logic done;
    logic err;

    sd_sector_buffer_if bus();

    sd_sector_buffer #(
        .START_SECTOR(START),
        .SECTOR_COUNT(NSEC),
        .ADDR_STEP   (STEP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_done(init_done),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Card content: every word of a sector is its address plus the word index.
    function automatic logic [15:0] exp_word(input int k, input int i);
        logic [31:0] a;
        a = START + STEP * 32'(k);
        return a[15:0] + 16'(i);
    endfunction

    // Shared bench state
    int rmode;
    int fail_at;
    bit release_rdy;
    int req_cnt;
    int good_cnt;
    int m_state;
    int deliv_cyc [0:7];
    int n_words;
    int ready_after_done;

    // Behavioural SD reader: accepts a request, raises busy, strobes words with gaps.
    initial begin : reader_model
        int          m_words;
        int          m_delay;
        int          m_target;
        logic [31:0] m_addr;
        bit          m_bad;
        bus.read_busy    = 1'b0;
        bus.read_request = 1'b0;
        bus.read_data    = '0;
        m_state = 0;
        req_cnt = 0;
        good_cnt = 0;
        m_words = 0;
        m_delay = 0;
        m_target = 256;
        m_addr = '0;
        m_bad = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            bus.read_request = 1'b0;
            if (!rst_n) begin
                m_state       = 0;
                bus.read_busy = 1'b0;
                req_cnt       = 0;
                good_cnt      = 0;
            end else begin
                case (m_state)
                    0: begin
                        if (bus.read_ready) begin
                            check("req_addr", bus.read_address, START + STEP * 32'(good_cnt));
                            m_addr   = bus.read_address;
                            m_bad    = (req_cnt == fail_at);
                            m_target = m_bad ? 200 : 256;
                            req_cnt++;
                            m_delay  = $urandom_range(2, 0);
                            m_state  = 1;
                        end
                    end
                    1: begin
                        if (m_delay == 0) begin
                            bus.read_busy = 1'b1;
                            m_words = 0;
                            m_state = 2;
                        end else begin
                            m_delay--;
                        end
                    end
                    default: begin
                        if (m_words == m_target) begin
                            bus.read_busy = 1'b0;
                            m_state = 0;
                            if (!m_bad) begin
                                if (good_cnt < 8) deliv_cyc[good_cnt] = cyc;
                                good_cnt++;
                            end
                        end else if ($urandom_range(3, 0) != 0) begin
                            bus.read_request = 1'b1;
                            bus.read_data = m_bad ? ~(m_addr[15:0] + 16'(m_words))
                                                  : (m_addr[15:0] + 16'(m_words));
                            m_words++;
                        end
                    end
                endcase
            end
        end
    end

    // Consumer: chooses out_ready, scores every accepted word against the card content.
    initial begin : consumer
        bit          prev_stall;
        logic [15:0] prev_data;
        bit          gap_chk;
        bit          done_chk;
        int          k;
        int          i;
        bus.out_ready = 1'b0;
        n_words = 0;
        ready_after_done = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        gap_chk = 1'b0;
        done_chk = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                n_words    = 0;
                prev_stall = 1'b0;
                gap_chk    = 1'b0;
                done_chk   = 1'b0;
            end else begin
                if (gap_chk) check("no_gap_valid", bus.out_valid, 1'b1);
                if (done_chk) check("done_after_last", done, 1'b1);
                if (prev_stall) begin
                    check("hold_valid", bus.out_valid, 1'b1);
                    check("hold_data", bus.out_data, prev_data);
                end
                gap_chk  = 1'b0;
                done_chk = 1'b0;
                if (done && bus.read_ready) ready_after_done++;
                case (rmode)
                    0:       bus.out_ready = 1'b1;
                    1:       bus.out_ready = 1'($urandom_range(1, 0));
                    2:       bus.out_ready = ~bus.out_ready;
                    default: bus.out_ready = release_rdy;
                endcase
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                if (bus.out_valid && bus.out_ready) begin
                    k = n_words / 256;
                    i = n_words % 256;
                    check("data", bus.out_data, exp_word(k, i));
                    check("last", bus.out_last, (i == 255));
                    check("sector", bus.out_sector, k);
                    if (i == 255 && good_cnt >= k + 2 && k + 1 < 8 && cyc - deliv_cyc[k + 1] >= 2)
                        gap_chk = 1'b1;
                    if (n_words == NSEC * 256 - 1) begin
                        check("done_early", done, 1'b0);
                        done_chk = 1'b1;
                    end
                    n_words++;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_read_ready"}, bus.read_ready, 1'b0);
        check({tag, "_read_address"}, bus.read_address, START);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_data"}, bus.out_data, 16'h0);
        check({tag, "_out_last"}, bus.out_last, 1'b0);
        check({tag, "_out_sector"}, bus.out_sector, 16'h0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    task automatic run_test(input int mode, input int fail, input bit exp_err, input bit mid);
        int budget;
        rmode = mode;
        fail_at = fail;
        release_rdy = (mode != 3);
        @(negedge clk);
        rst_n = 1'b0;
        init_done = 1'b0;
        @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        ready_after_done = 0;
        repeat (3) @(negedge clk);
        check("wait_init_ready", bus.read_ready, 1'b0);
        init_done = 1'b1;
        if (mode == 3) begin
            budget = 0;
            while (!(req_cnt == 2 && m_state == 0) && budget < 5000) begin
                @(negedge clk);
                budget++;
            end
            repeat (40) @(negedge clk);
            check("stall_ready", bus.read_ready, 1'b0);
            check("stall_reqs", req_cnt, 2);
            check("stall_valid", bus.out_valid, 1'b1);
            check("stall_data", bus.out_data, exp_word(0, 0));
            check("stall_words", n_words, 0);
            release_rdy = 1'b1;
        end
        if (mid) begin
            budget = 0;
            while (n_words < 100 && budget < 5000) begin
                @(negedge clk);
                budget++;
            end
            check("mid_reached", (n_words >= 100), 1'b1);
            rst_n = 1'b0;
            @(negedge clk);
            check_reset("midrst");
            rst_n = 1'b1;
        end
        budget = 0;
        while (!done && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        check("done", done, 1'b1);
        repeat (30) @(negedge clk);
        check("words", n_words, NSEC * 256);
        check("err", err, exp_err);
        check("reqs", req_cnt, NSEC + ((fail >= 0) ? 1 : 0));
        check("ready_after_done", ready_after_done, 0);
        check("sector_end", bus.out_sector, NSEC);
        check("valid_end", bus.out_valid, 1'b0);
    endtask

    initial begin : main
        rst_n = 1'b0;
        init_done = 1'b0;
        rmode = 0;
        fail_at = -1;
        release_rdy = 1'b1;
        run_test(0, -1, 1'b0, 1'b0);
        run_test(1, -1, 1'b0, 1'b0);
        run_test(3, -1, 1'b0, 1'b0);
        run_test(2, -1, 1'b0, 1'b0);
        run_test(0,  1, 1'b1, 1'b0);
        run_test(0, -1, 1'b0, 1'b1);
        run_test(1,  2, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
